laser_cover_scorer: RTL and testbench
=====================================

# laser_cover_scorer

Downstream checker for the two-circle laser placement engine. Snoops the same 40-object coordinate stream that feeds the engine and latches the engine's final circle centres on its DONE pulse. Then counts, one object per cycle, how many objects lie inside circle 1, circle 2, or both (radius 4, Euclidean). Reports the coverage score for self-checking and for host readout.

## Interface
Parameters:
- N_OBJ, 40: objects per frame.
- RADIUS_SQ, 16: inclusion threshold; an object is inside a circle when dx²+dy² ≤ RADIUS_SQ.

Ports:
- CLK, input, 1: single clock, rising edge.
- RST, input, 1: asynchronous, active-high reset.
- SYNC, input, 1: synchronous frame restart. Tied to the engine's frame-start pulse.
- OBJ_VALID, input, 1: X/Y carry one object this cycle.
- X, input, 4: object x coordinate.
- Y, input, 4: object y coordinate.
- DONE, input, 1: engine result strobe, one cycle wide.
- C1X, input, 4: circle 1 centre x, sampled when DONE=1.
- C1Y, input, 4: circle 1 centre y, sampled when DONE=1.
- C2X, input, 4: circle 2 centre x, sampled when DONE=1.
- C2Y, input, 4: circle 2 centre y, sampled when DONE=1.
- COVER, output, 6: number of objects inside circle 1 OR circle 2.
- BOTH, output, 6: number of objects inside both circles.
- SCORE_VALID, output, 1: one-cycle pulse when COVER and BOTH update.
- OBJ_DROP, output, 1: sticky; set when OBJ_VALID=1 is seen outside CAPTURE.
- PROTO_ERR, output, 1: sticky; set when DONE=1 is seen outside WAIT_DONE.

## Operation
- Storage: 40×8-bit object buffer, write index wr_idx (6 bits), read index rd_idx (6 bits), latched centres, two 6-bit accumulators.
- States and transitions:
  - CAPTURE: each OBJ_VALID writes {Y,X} to buf[wr_idx] and increments wr_idx. The write with wr_idx==N_OBJ-1 goes to WAIT_DONE.
  - WAIT_DONE: on DONE=1, latch C1X/C1Y/C2X/C2Y, clear both accumulators, set rd_idx=0, go to SCAN.
  - SCAN: each cycle evaluate buf[rd_idx] against both latched centres, then rd_idx++.
    - Inside either circle: increment the COVER accumulator.
    - Inside both circles: increment the BOTH accumulator.
    - When rd_idx==N_OBJ-1 is evaluated, go to REPORT.
  - REPORT: copy the accumulators to COVER/BOTH, pulse SCORE_VALID, clear wr_idx, go to CAPTURE.
- Distance arithmetic: dx=|ox−cx|, dy=|oy−cy|, 4 bits unsigned each. dx²+dy² computed at 9 bits with no overflow; compared ≤ RADIUS_SQ. Coordinates cover 0..15 with no wrap; a centre at 15 never covers x=0.
- COVER/BOTH hold their values between REPORTs. Accumulators never exceed 40.
- SYNC=1 in any state: wr_idx=0, rd_idx=0, accumulators cleared, go to CAPTURE.
  - Outputs COVER/BOTH/flags are unchanged.
  - An OBJ_VALID in the same cycle as SYNC is captured as object 0.
- DONE in CAPTURE, SCAN or REPORT: ignored, PROTO_ERR set.
- OBJ_VALID in WAIT_DONE, SCAN or REPORT: data discarded, OBJ_DROP set.
- OBJ_DROP and PROTO_ERR clear only on RST.

## Timing
- Reset values: state=CAPTURE; wr_idx=rd_idx=0; COVER=0, BOTH=0, SCORE_VALID=0, OBJ_DROP=0, PROTO_ERR=0; latched centres 0.
- RST asserted mid-SCAN aborts immediately. No SCORE_VALID is produced for the aborted frame.
- The 40th OBJ_VALID at edge t puts the block in WAIT_DONE from cycle t+1. A DONE in that same cycle t is a PROTO_ERR.
- DONE sampled at edge d: SCAN covers cycles d+1..d+40 (one object per cycle). REPORT is in cycle d+41.
- SCORE_VALID is high for cycle d+41 only. COVER/BOTH are valid from d+41 and held until the next REPORT.
- Fixed latency of 41 cycles from DONE to SCORE_VALID. No backpressure.
- The next frame's objects are accepted from cycle d+42.

## Test plan
- Full coverage: 40 objects at (5,5), DONE with C1=(5,5), C2=(15,15) -> SCORE_VALID 41 cycles after DONE, COVER=40, BOTH=0.
- Radius boundary: C1=C2=(4,4); 8 each of (4,0), (6,7), (7,6) [inside] and 8 each of (7,7), (0,3) [outside] -> COVER=24, BOTH=24.
- Overlap: C1=(3,3), C2=(6,3); 20 objects at (4,3) and 20 at (0,0) -> COVER=20, BOTH=20.
- Protocol errors:
  - DONE after 10 objects -> PROTO_ERR=1, no SCORE_VALID. Finish the remaining 30 objects plus a proper DONE -> normal score.
  - OBJ_VALID during SCAN -> OBJ_DROP=1, score unaffected.
- Restart and reset:
  - SYNC at SCAN cycle 20 -> no SCORE_VALID; the next 40 objects are captured from index 0; the previous COVER value is retained.
  - RST mid-SCAN -> all outputs 0 on the next sample.

Source files
------------

// File: rtl/laser_cover_scorer.sv
// Captures a 40-object frame, latches the engine's circle centres on DONE and scores one object per cycle.
// SCORE_VALID pulses 41 cycles after DONE; there is no backpressure, so objects arriving outside CAPTURE are dropped.
module laser_cover_scorer #(
  parameter int N_OBJ     = 40,
  parameter int RADIUS_SQ = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SYNC,
  input  logic       OBJ_VALID,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic [5:0] COVER,
  output logic [5:0] BOTH,
  output logic       SCORE_VALID,
  output logic       OBJ_DROP,
  output logic       PROTO_ERR
);

  localparam int IW = 6;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] x;
  } obj_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } pt_t;

  typedef enum logic [1:0] {
    CAPTURE,
    WAIT_DONE,
    SCAN,
    REPORT
  } state_t;

  state_t        state;
  obj_t          obj_buf [N_OBJ];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  pt_t           c1;
  pt_t           c2;
  logic [5:0]    cov_acc;
  logic [5:0]    both_acc;

  obj_t          cur_obj;
  logic          in1;
  logic          in2;
  logic [5:0]    cov_nxt;
  logic [5:0]    both_nxt;
  logic          last_wr;
  logic          last_rd;
  logic          cap_we;
  logic [IW-1:0] cap_idx;

  // Squares are taken at 9 bits so 15^2+15^2 cannot wrap into the inside range.
  function automatic logic in_circle(input obj_t o, input pt_t c);
    logic [3:0] dx;
    logic [3:0] dy;
    logic [8:0] dx9;
    logic [8:0] dy9;
    logic [8:0] d2;
    dx  = (o.x >= c.x) ? (o.x - c.x) : (c.x - o.x);
    dy  = (o.y >= c.y) ? (o.y - c.y) : (c.y - o.y);
    dx9 = {5'd0, dx};
    dy9 = {5'd0, dy};
    d2  = dx9 * dx9 + dy9 * dy9;
    return d2 <= 9'(RADIUS_SQ);
  endfunction

  always_comb begin
    cur_obj  = obj_buf[rd_idx];
    in1      = in_circle(cur_obj, c1);
    in2      = in_circle(cur_obj, c2);
    cov_nxt  = cov_acc + {5'd0, in1 | in2};
    both_nxt = both_acc + {5'd0, in1 & in2};
    last_wr  = (wr_idx == IW'(N_OBJ - 1));
    last_rd  = (rd_idx == IW'(N_OBJ - 1));
    // A SYNC restarts the frame, so a coincident object becomes object 0.
    cap_we   = OBJ_VALID && (SYNC || (state == CAPTURE));
    cap_idx  = SYNC ? '0 : wr_idx;
  end

  always_ff @(posedge CLK) begin
    if (cap_we) begin
      obj_buf[cap_idx] <= {Y, X};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= CAPTURE;
      wr_idx      <= '0;
      rd_idx      <= '0;
      c1          <= '0;
      c2          <= '0;
      cov_acc     <= '0;
      both_acc    <= '0;
      COVER       <= '0;
      BOTH        <= '0;
      SCORE_VALID <= 1'b0;
      OBJ_DROP    <= 1'b0;
      PROTO_ERR   <= 1'b0;
    end else begin
      SCORE_VALID <= 1'b0;
      if (DONE && (state != WAIT_DONE)) begin
        PROTO_ERR <= 1'b1;
      end
      if (OBJ_VALID && (state != CAPTURE) && !SYNC) begin
        OBJ_DROP <= 1'b1;
      end
      if (SYNC) begin
        state    <= CAPTURE;
        wr_idx   <= OBJ_VALID ? IW'(1) : '0;
        rd_idx   <= '0;
        cov_acc  <= '0;
        both_acc <= '0;
      end else begin
        case (state)
          CAPTURE: begin
            if (OBJ_VALID) begin
              wr_idx <= wr_idx + IW'(1);
              if (last_wr) begin
                state <= WAIT_DONE;
              end
            end
          end
          WAIT_DONE: begin
            if (DONE) begin
              c1       <= {C1X, C1Y};
              c2       <= {C2X, C2Y};
              cov_acc  <= '0;
              both_acc <= '0;
              rd_idx   <= '0;
              state    <= SCAN;
            end
          end
          SCAN: begin
            cov_acc  <= cov_nxt;
            both_acc <= both_nxt;
            rd_idx   <= rd_idx + IW'(1);
            // Outputs load on the last evaluation so they are valid in the REPORT cycle.
            if (last_rd) begin
              COVER       <= cov_nxt;
              BOTH        <= both_nxt;
              SCORE_VALID <= 1'b1;
              state       <= REPORT;
            end
          end
          REPORT: begin
            wr_idx <= '0;
            state  <= CAPTURE;
          end
          default: state <= CAPTURE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_laser_cover_scorer.sv
// Randomized and directed bench for laser_cover_scorer against a frame-level reference model.
module tb_laser_cover_scorer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SYNC = 1'b0;
  logic       OBJ_VALID = 1'b0;
  logic [3:0] X = '0;
  logic [3:0] Y = '0;
  logic       DONE = 1'b0;
  logic [3:0] C1X = '0;
  logic [3:0] C1Y = '0;
  logic [3:0] C2X = '0;
  logic [3:0] C2Y = '0;
  logic [5:0] COVER;
  logic [5:0] BOTH;
  logic       SCORE_VALID;
  logic       OBJ_DROP;
  logic       PROTO_ERR;

  int vectors = 0;
  int miscompares = 0;
  bit running = 1'b1;

  logic [3:0] fx [40];
  logic [3:0] fy [40];

  laser_cover_scorer dut (
    .CLK(CLK), .RST(RST), .SYNC(SYNC), .OBJ_VALID(OBJ_VALID), .X(X), .Y(Y),
    .DONE(DONE), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .COVER(COVER), .BOTH(BOTH), .SCORE_VALID(SCORE_VALID),
    .OBJ_DROP(OBJ_DROP), .PROTO_ERR(PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  // Reference model: collects the frame, scores it in one go on DONE, then releases the
  // result after the fixed 40-cycle scan delay.
  localparam int M_CAP = 0, M_WAIT = 1, M_SCAN = 2, M_REP = 3;
  int m_mode = M_CAP;
  int m_x [40];
  int m_y [40];
  int m_n = 0, m_cnt = 0, m_pcov = 0, m_pboth = 0;
  int e_cover = 0, e_both = 0;
  int e_sv = 0, e_drop = 0, e_perr = 0;

  function automatic int covers(input int ox, input int oy, input int cx, input int cy);
    return ((ox - cx) * (ox - cx) + (oy - cy) * (oy - cy) <= 16) ? 1 : 0;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_mode = M_CAP; m_n = 0; m_cnt = 0;
      e_cover = 0; e_both = 0; e_sv = 0; e_drop = 0; e_perr = 0;
    end else begin
      e_sv = 0;
      if (DONE && m_mode != M_WAIT) e_perr = 1;
      if (OBJ_VALID && m_mode != M_CAP && !SYNC) e_drop = 1;
      if (SYNC) begin
        m_mode = M_CAP;
        m_n = 0;
        if (OBJ_VALID) begin m_x[0] = int'(X); m_y[0] = int'(Y); m_n = 1; end
      end else begin
        case (m_mode)
          M_CAP: if (OBJ_VALID) begin
            m_x[m_n] = int'(X); m_y[m_n] = int'(Y);
            m_n++;
            if (m_n == 40) m_mode = M_WAIT;
          end
          M_WAIT: if (DONE) begin
            m_pcov = 0; m_pboth = 0;
            for (int i = 0; i < 40; i++) begin
              int a, b;
              a = covers(m_x[i], m_y[i], int'(C1X), int'(C1Y));
              b = covers(m_x[i], m_y[i], int'(C2X), int'(C2Y));
              if (a + b > 0) m_pcov++;
              if (a + b == 2) m_pboth++;
            end
            m_cnt = 40;
            m_mode = M_SCAN;
          end
          M_SCAN: begin
            m_cnt--;
            if (m_cnt == 0) begin
              e_cover = m_pcov; e_both = m_pboth; e_sv = 1;
              m_mode = M_REP;
            end
          end
          default: begin m_n = 0; m_mode = M_CAP; end
        endcase
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (running) begin
      vectors++;
      check("COVER", int'(COVER), e_cover);
      check("BOTH", int'(BOTH), e_both);
      check("SCORE_VALID", int'(SCORE_VALID), e_sv);
      check("OBJ_DROP", int'(OBJ_DROP), e_drop);
      check("PROTO_ERR", int'(PROTO_ERR), e_perr);
    end
  end

  task automatic step(input bit ov, input logic [3:0] x, input logic [3:0] y,
                      input bit done, input bit sync);
    @(negedge CLK);
    OBJ_VALID = ov; X = x; Y = y; DONE = done; SYNC = sync;
  endtask

  task automatic send_objs(input int first, input int count, input bit gaps);
    for (int i = first; i < first + count; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      step(1'b1, fx[i], fy[i], 1'b0, 1'b0);
    end
  endtask

  task automatic fire_done(input logic [3:0] ax, input logic [3:0] ay,
                           input logic [3:0] bx, input logic [3:0] by);
    @(negedge CLK);
    OBJ_VALID = 1'b0; SYNC = 1'b0; DONE = 1'b1;
    C1X = ax; C1Y = ay; C2X = bx; C2Y = by;
  endtask

  // Returns the cycle count from DONE to SCORE_VALID, or 0 if none within the bound.
  task automatic wait_score(input int drop_at, input int sync_at, output int lat);
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      OBJ_VALID = (c == drop_at); X = 4'($urandom); Y = 4'($urandom);
      DONE = 1'b0; SYNC = (c == sync_at);
      if (SCORE_VALID) begin lat = c; break; end
    end
    @(negedge CLK);
    OBJ_VALID = 1'b0; SYNC = 1'b0;
  endtask

  function automatic logic [3:0] near(input logic [3:0] c);
    int v;
    v = int'(c) + $urandom_range(0, 10) - 5;
    if (v < 0) v = 0;
    if (v > 15) v = 15;
    return 4'(v);
  endfunction

  initial begin
    int lat;
    logic [3:0] ax, ay, bx, by;

    repeat (2) @(negedge CLK);
    check("reset COVER", int'(COVER), 0);
    check("reset BOTH", int'(BOTH), 0);
    check("reset SCORE_VALID", int'(SCORE_VALID), 0);
    check("reset OBJ_DROP", int'(OBJ_DROP), 0);
    check("reset PROTO_ERR", int'(PROTO_ERR), 0);
    RST = 1'b0;

    // Full coverage.
    for (int i = 0; i < 40; i++) begin fx[i] = 4'd5; fy[i] = 4'd5; end
    send_objs(0, 40, 1'b0);
    fire_done(4'd5, 4'd5, 4'd15, 4'd15);
    wait_score(0, 0, lat);
    check("full latency", lat, 41);
    check("full COVER", int'(COVER), 40);
    check("full BOTH", int'(BOTH), 0);

    // Radius boundary: distance^2 of exactly 16 is inside, 17 and 18 are outside.
    for (int i = 0; i < 40; i++) begin
      case (i / 8)
        0: begin fx[i] = 4'd4; fy[i] = 4'd0; end
        1: begin fx[i] = 4'd6; fy[i] = 4'd7; end
        2: begin fx[i] = 4'd7; fy[i] = 4'd6; end
        3: begin fx[i] = 4'd7; fy[i] = 4'd7; end
        default: begin fx[i] = 4'd0; fy[i] = 4'd3; end
      endcase
    end
    send_objs(0, 40, 1'b1);
    fire_done(4'd4, 4'd4, 4'd4, 4'd4);
    wait_score(0, 0, lat);
    check("radius latency", lat, 41);
    check("radius COVER", int'(COVER), 24);
    check("radius BOTH", int'(BOTH), 24);

    // Overlapping circles.
    for (int i = 0; i < 40; i++) begin
      fx[i] = (i < 20) ? 4'd4 : 4'd0;
      fy[i] = (i < 20) ? 4'd3 : 4'd0;
    end
    send_objs(0, 40, 1'b0);
    fire_done(4'd3, 4'd3, 4'd6, 4'd3);
    wait_score(0, 0, lat);
    check("overlap COVER", int'(COVER), 20);
    check("overlap BOTH", int'(BOTH), 20);

    // SYNC mid-scan: no score, previous result held.
    for (int i = 0; i < 40; i++) begin fx[i] = 4'($urandom); fy[i] = 4'($urandom); end
    send_objs(0, 40, 1'b0);
    fire_done(4'd8, 4'd8, 4'd2, 4'd12);
    wait_score(0, 20, lat);
    check("sync no score", lat, 0);
    check("sync COVER held", int'(COVER), 20);
    check("sync BOTH held", int'(BOTH), 20);

    // Early DONE is an error and is ignored; the frame still completes normally.
    for (int i = 0; i < 40; i++) begin fx[i] = 4'd5; fy[i] = 4'd5; end
    send_objs(0, 10, 1'b0);
    fire_done(4'd0, 4'd0, 4'd0, 4'd0);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    check("early DONE PROTO_ERR", int'(PROTO_ERR), 1);
    send_objs(10, 30, 1'b0);
    fire_done(4'd5, 4'd5, 4'd5, 4'd9);
    wait_score(0, 0, lat);
    check("proto latency", lat, 41);
    check("proto COVER", int'(COVER), 40);
    check("proto BOTH", int'(BOTH), 40);

    // Object during scan is dropped without disturbing the score.
    for (int i = 0; i < 40; i++) begin fx[i] = near(4'd7); fy[i] = near(4'd7); end
    send_objs(0, 40, 1'b1);
    fire_done(4'd7, 4'd7, 4'd9, 4'd6);
    wait_score(15, 0, lat);
    check("drop latency", lat, 41);
    check("drop OBJ_DROP", int'(OBJ_DROP), 1);

    // Random frames, including centres at the coordinate extremes.
    for (int f = 0; f < 12; f++) begin
      ax = 4'($urandom); ay = 4'($urandom);
      bx = (f % 3 == 0) ? 4'd15 : 4'($urandom);
      by = (f % 4 == 0) ? 4'd0 : 4'($urandom);
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 1) == 1) begin fx[i] = near(ax); fy[i] = near(ay); end
        else begin fx[i] = near(bx); fy[i] = near(by); end
      end
      send_objs(0, 40, 1'b1);
      fire_done(ax, ay, bx, by);
      wait_score(0, 0, lat);
      check("random latency", lat, 41);
    end

    // Reset mid-scan aborts the frame and clears every output.
    for (int i = 0; i < 40; i++) begin fx[i] = 4'd5; fy[i] = 4'd5; end
    send_objs(0, 40, 1'b0);
    fire_done(4'd5, 4'd5, 4'd5, 4'd5);
    repeat (20) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    #2 RST = 1'b1;
    @(negedge CLK);
    check("rst COVER", int'(COVER), 0);
    check("rst BOTH", int'(BOTH), 0);
    check("rst SCORE_VALID", int'(SCORE_VALID), 0);
    check("rst OBJ_DROP", int'(OBJ_DROP), 0);
    check("rst PROTO_ERR", int'(PROTO_ERR), 0);
    RST = 1'b0;
    repeat (3) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    send_objs(0, 40, 1'b0);
    fire_done(4'd5, 4'd5, 4'd15, 4'd15);
    wait_score(0, 0, lat);
    check("post-reset latency", lat, 41);
    check("post-reset COVER", int'(COVER), 40);

    repeat (2) @(negedge CLK);
    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
